// File: rtl/tvc_pkg.sv
// tvc_pkg: constants and types shared by the coordinate button-entry transmitter and receiver.
package tvc_pkg;
    localparam int COORD_BITS = 4;
    localparam int MAX_COORD = 9;
    localparam logic BUTTON_PRESSED = 1'b0;
    localparam logic BUTTON_RELEASED = 1'b1;
    typedef enum logic [2:0] {IDLE, PRESS, GAP, ACT_PRESS, ACT_GAP, DONE} emitter_state_t;
    function automatic int max_of(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/press_timer.sv
// press_timer: loadable down-counter whose terminal-count flag times every press and gap.
module press_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             tc
);
    logic [WIDTH-1:0] count;
    always_ff @(posedge clk) begin
        if (reset) count <= '0;
        else if (load) count <= load_value;
        else if (count != '0) count <= count - 1'b1;
    end
    assign tc = count == '0;
endmodule

// File: rtl/coordinate_emitter.sv
// coordinate_emitter: replays an (x, y) coordinate as active-low button presses, x then y LSB first, then activity.
module coordinate_emitter
    import tvc_pkg::*;
#(
    parameter int PRESS_CYCLES = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [COORD_BITS-1:0] x_in,
    input  logic [COORD_BITS-1:0] y_in,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  logic_0_button,
    output logic                  logic_1_button,
    output logic                  activity_button
);
    localparam int TW = max_of($clog2(max_of(PRESS_CYCLES, GAP_CYCLES)), 1);
    localparam int IW = $clog2(2 * COORD_BITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(2 * COORD_BITS - 1);
    localparam logic [COORD_BITS-1:0] MAX_C = COORD_BITS'(MAX_COORD);
    localparam logic [TW-1:0] PRESS_LD = TW'(PRESS_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LD = TW'(GAP_CYCLES - 1);

    emitter_state_t state, state_next;
    logic [2*COORD_BITS-1:0] shreg, shreg_next;
    logic [IW-1:0] bit_idx, idx_next;
    logic reject, tc;

    press_timer #(.WIDTH(TW)) u_timer (
        .clk(clk),
        .reset(reset),
        .load(state_next != state),
        .load_value((state_next == PRESS || state_next == ACT_PRESS) ? PRESS_LD : GAP_LD),
        .tc(tc)
    );

    always_comb begin
        state_next = state;
        shreg_next = shreg;
        idx_next = bit_idx;
        reject = 1'b0;
        case (state)
            IDLE: if (start) begin
                if (x_in > MAX_C || y_in > MAX_C) begin
                    reject = 1'b1;
                end else begin
                    state_next = PRESS;
                    shreg_next = {y_in, x_in};
                    idx_next = '0;
                end
            end
            PRESS: if (tc) state_next = GAP;
            GAP: if (tc) begin
                state_next = (bit_idx == LAST_IDX) ? ACT_PRESS : PRESS;
                shreg_next = shreg >> 1;
                idx_next = bit_idx + 1'b1;
            end
            ACT_PRESS: if (tc) state_next = ACT_GAP;
            ACT_GAP: if (tc) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they land in the same cycle as the state itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            bit_idx <= '0;
            ready <= 1'b1;
            busy <= 1'b0;
            done <= 1'b0;
            error <= 1'b0;
            logic_0_button <= BUTTON_RELEASED;
            logic_1_button <= BUTTON_RELEASED;
            activity_button <= BUTTON_RELEASED;
        end else begin
            state <= state_next;
            shreg <= shreg_next;
            bit_idx <= idx_next;
            ready <= state_next == IDLE;
            busy <= state_next inside {PRESS, GAP, ACT_PRESS, ACT_GAP};
            done <= state_next == DONE;
            error <= reject;
            logic_0_button <= (state_next == PRESS && !shreg_next[0]) ? BUTTON_PRESSED : BUTTON_RELEASED;
            logic_1_button <= (state_next == PRESS && shreg_next[0]) ? BUTTON_PRESSED : BUTTON_RELEASED;
            activity_button <= (state_next == ACT_PRESS) ? BUTTON_PRESSED : BUTTON_RELEASED;
        end
    end
endmodule

// File: doc/coordinate_emitter.md
Name: coordinate_emitter

Overview:
Transmit side of the button-entry protocol that `input_handler` receives. The block takes a parallel (x, y) board coordinate and replays it as the active-low press sequence a player would enter by hand:
- 4 bits of x, LSB first;
- then 4 bits of y, LSB first;
- then one activity press.

It drives the `logic_0_button`, `logic_1_button` and `activity_button` inputs of `input_handler`. Uses: CPU/AI player moves and bench loopback.

Parameters:
- COORD_BITS, 4, bits per coordinate.
- MAX_COORD, 9, largest legal coordinate value (board 0..9).
- PRESS_CYCLES, 2, clock cycles a button is held low per press (>=1).
- GAP_CYCLES, 2, clock cycles all buttons are held high after each press (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to emit the coordinate on x_in/y_in.
- x_in  in  COORD_BITS  x coordinate, sampled on accepted start.
- y_in  in  COORD_BITS  y coordinate, sampled on accepted start.
- ready  out  1  high only in IDLE; start is accepted when start && ready.
- busy  out  1  high from the cycle after acceptance through the last gap.
- done  out  1  one-cycle pulse after the activity press gap completes.
- error  out  1  one-cycle pulse when start is rejected for an out-of-range coordinate.
- logic_0_button  out  1  active-low; pressed for a 0 bit.
- logic_1_button  out  1  active-low; pressed for a 1 bit.
- activity_button  out  1  active-low; pressed once to commit the coordinate.

Behaviour:
- All outputs are registered. Reset values: the three buttons = 1; ready = 1; busy, done, error = 0; state = IDLE; shift register and counters = 0.
- States: IDLE, PRESS, GAP, ACT_PRESS, ACT_GAP, DONE.
- IDLE with start=1 and x_in<=MAX_COORD and y_in<=MAX_COORD:
  - load shift register {y_in, x_in}; bit_idx=0; go to PRESS.
  - The first button goes low on the cycle after acceptance (latency 1).
- IDLE with start=1 and either coordinate > MAX_COORD:
  - error=1 for one cycle; stay in IDLE; no presses are emitted.
- PRESS: drive logic_1_button=0 if shreg[0]=1, else logic_0_button=0. Only one button is low at a time. Hold for PRESS_CYCLES, then go to GAP.
- GAP: all buttons high for GAP_CYCLES. Then:
  - shift shreg right; bit_idx++;
  - if bit_idx reaches 2*COORD_BITS-1 (the last bit's gap), go to ACT_PRESS; otherwise go to PRESS.
- ACT_PRESS: activity_button=0 for PRESS_CYCLES, then go to ACT_GAP.
- ACT_GAP: all buttons high for GAP_CYCLES, then go to DONE.
- DONE: done=1 and ready=0 for exactly one cycle, then go to IDLE.
- Total duration from acceptance to done: (2*COORD_BITS+1)*(PRESS_CYCLES+GAP_CYCLES) cycles, plus 1 for DONE. With defaults, done is high 37 cycles after the accepting edge.
- start while busy or in DONE: ignored; the in-flight sequence and latched coordinate are unaffected.
- x_in/y_in changes after acceptance have no effect.
- A single shared cycle counter is reloaded on every state entry; it is sized for max(PRESS_CYCLES, GAP_CYCLES).
- Reset mid-sequence: at the reset edge, buttons return to 1, state goes to IDLE, and a pending done/error is cleared. No partial activity press is ever emitted.
- MAX_COORD = 2^COORD_BITS-1 disables range checking; error never fires.

Decomposition:
- Shared package `tvc_pkg`:
  - COORD_BITS and MAX_COORD constants;
  - emitter state enum;
  - BUTTON_PRESSED=1'b0 / BUTTON_RELEASED=1'b1 constants, shared with `input_handler`.
- One natural sub-module, `press_timer`: a loadable down-counter with a terminal-count flag, sized by max(PRESS_CYCLES, GAP_CYCLES). Used by every timed state.

Test Plan:
- Emit (1,3) with defaults.
  - Required: button press order 1,0,0,0,1,1,0,0 on logic_1/logic_0, then activity.
  - Each press is 2 cycles low and 2 cycles high; done pulses 37 cycles after acceptance.
- Loopback into `input_handler` with coordinate (9,0).
  - Required: x_output=1001, y_output=0000, and valid_coordinate asserted after the activity press.
- start with x_in=10, y_in=2.
  - Required: error=1 for one cycle, all buttons stay 1, ready stays 1, no done.
- start re-asserted with (5,5) during busy of a (2,7) emission.
  - Required: the sequence matches (2,7) only (0,1,0,0,1,1,1,0, activity); one done.
- reset=1 on the 3rd bit's PRESS.
  - Required: next cycle all buttons = 1, ready=1, busy=0.
  - A following start with (4,4) emits a clean full sequence.
- start held high continuously.
  - Required: a new acceptance occurs only on the cycle after DONE; back-to-back sequences are separated by exactly one ready cycle.
